// File: rtl/mm_console_pkg.sv
// +--------------------------------------------------------------------+
// | mm_console_pkg: framing byte codes and decoder states for the      |
// | console byte/packet converters.                     Revision 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

package mm_console_pkg;

  localparam logic [7:0] SOP_BYTE  = 8'h7A;
  localparam logic [7:0] EOP_BYTE  = 8'h7B;
  localparam logic [7:0] CHAN_BYTE = 8'h7C;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [1:0] {
    S_DATA     = 2'd0,
    S_ESC      = 2'd1,
    S_CHAN     = 2'd2,
    S_CHAN_ESC = 2'd3
  } b2p_state_t;

  function automatic logic is_marker(input logic [7:0] b);
    return (b == SOP_BYTE) || (b == EOP_BYTE) || (b == CHAN_BYTE) || (b == ESC_BYTE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mm_console_master_b2p_if.sv
// +--------------------------------------------------------------------+
// | mm_console_master_b2p_if: raw byte input and packetised output.    |
// |                                                    Revision 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

interface mm_console_master_b2p_if #(
  parameter int CHANNEL_WIDTH = 8
);
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic                     out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket,
           out_endofpacket, out_channel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket,
           out_endofpacket, out_channel
  );
endinterface

`default_nettype wire

// File: rtl/mm_console_master_b2p.sv
// +--------------------------------------------------------------------+
// | mm_console_master_b2p: strips in-band framing bytes and emits a    |
// | registered Avalon-ST packet stream.                 Revision 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module mm_console_master_b2p
  import mm_console_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  mm_console_master_b2p_if.slave      bus
);

  b2p_state_t state_q, state_d;
  logic [7:0] chan_q, chan_d;
  logic       sop_pend_q, sop_pend_d;
  logic       eop_pend_q, eop_pend_d;

  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;
  logic [CHANNEL_WIDTH-1:0] out_chan_q, out_chan_d;

  logic       in_ready;
  logic       accept;
  logic       emit;
  logic [7:0] emit_data;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    sop_pend_d = sop_pend_q;
    eop_pend_d = eop_pend_q;
    emit       = 1'b0;
    emit_data  = bus.in_data;

    if (accept) begin
      unique case (state_q)
        S_DATA: begin
          if (bus.in_data == SOP_BYTE)       sop_pend_d = 1'b1;
          else if (bus.in_data == EOP_BYTE)  eop_pend_d = 1'b1;
          else if (bus.in_data == CHAN_BYTE) state_d    = S_CHAN;
          else if (bus.in_data == ESC_BYTE)  state_d    = S_ESC;
          else                               emit       = 1'b1;
        end
        S_ESC: begin
          // Escaped payload is always data, even if it decodes to a marker code.
          emit      = 1'b1;
          emit_data = bus.in_data ^ ESC_XOR;
          state_d   = S_DATA;
        end
        S_CHAN: begin
          if (bus.in_data == ESC_BYTE)       state_d    = S_CHAN_ESC;
          else if (bus.in_data == SOP_BYTE)  sop_pend_d = 1'b1;
          else if (bus.in_data == EOP_BYTE)  eop_pend_d = 1'b1;
          else if (bus.in_data == CHAN_BYTE) state_d    = S_CHAN;
          else begin
            chan_d  = bus.in_data;
            state_d = S_DATA;
          end
        end
        S_CHAN_ESC: begin
          chan_d  = bus.in_data ^ ESC_XOR;
          state_d = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end

    if (emit) begin
      sop_pend_d = 1'b0;
      eop_pend_d = 1'b0;
    end
  end

  // Output slice: load on emit, drain on transfer, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_chan_d  = out_chan_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_data;
      out_sop_d   = sop_pend_q;
      out_eop_d   = eop_pend_q;
      out_chan_d  = chan_q[CHANNEL_WIDTH-1:0];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_DATA;
      chan_q      <= '0;
      sop_pend_q  <= 1'b0;
      eop_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      sop_pend_q  <= sop_pend_d;
      eop_pend_q  <= eop_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
  assign bus.out_channel       = out_chan_q;

endmodule

`default_nettype wire

// File: tb/tb_mm_console_master_b2p.sv
// +--------------------------------------------------------------------+
// | tb_mm_console_master_b2p: directed self-checking bench.            |
// |                                                    Revision 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mm_console_master_b2p;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  mm_console_master_b2p_if #(.CHANNEL_WIDTH(8)) bus ();

  mm_console_master_b2p #(.CHANNEL_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, sop, eop, channel, data}
  function automatic logic [18:0] obs_vec();
    return {bus.out_valid, bus.out_startofpacket, bus.out_endofpacket,
            bus.out_channel, bus.out_data};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one byte (out_ready high, so it is accepted on the next edge).
  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    chk(tag, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic sop,
                            input logic eop, input logic [7:0] ch);
    chk(tag, {13'd0, obs_vec()}, {13'd0, 1'b1, sop, eop, ch, d});
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_out", {13'd0, obs_vec()}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Plain stream
    send(8'h7A); expect_idle("plain_sop_marker");
    send(8'h11); expect_out("plain_11", 8'h11, 1'b1, 1'b0, 8'h00);
    send(8'h22); expect_out("plain_22", 8'h22, 1'b0, 1'b0, 8'h00);
    send(8'h7B); expect_idle("plain_eop_marker");
    send(8'h33); expect_out("plain_33", 8'h33, 1'b0, 1'b1, 8'h00);

    // Escapes
    send(8'h7D); expect_idle("esc1_marker");
    send(8'h5A); expect_out("esc_7a", 8'h7A, 1'b0, 1'b0, 8'h00);
    send(8'h7D); expect_idle("esc2_marker");
    send(8'h5D); expect_out("esc_7d", 8'h7D, 1'b0, 1'b0, 8'h00);

    // Channel select, single-byte packet, escaped channel
    send(8'h7C); send(8'h05); send(8'h7A); send(8'h7B);
    expect_idle("chan_markers");
    send(8'hAA); expect_out("chan5_aa", 8'hAA, 1'b1, 1'b1, 8'h05);
    send(8'h7C); send(8'h7D); send(8'h5C);
    expect_idle("chan_esc_markers");
    send(8'hBB); expect_out("chan7c_bb", 8'hBB, 1'b0, 1'b0, 8'h7C);

    // Marker inside channel state; repeated SOP is idempotent
    send(8'h7C); send(8'h7A); send(8'h7A); send(8'h09);
    expect_idle("chanmark_markers");
    send(8'h44); expect_out("chan9_44", 8'h44, 1'b1, 1'b0, 8'h09);

    // Backpressure
    send(8'h7A);
    send(8'h01); expect_out("bp_01", 8'h01, 1'b1, 1'b0, 8'h09);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h02;
    #1;
    chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect_out("bp_hold", 8'h01, 1'b1, 1'b0, 8'h09);
      chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_out("bp_02", 8'h02, 1'b0, 1'b0, 8'h09);
    send(8'h7B); expect_idle("bp_eop_marker");
    send(8'h03); expect_out("bp_03", 8'h03, 1'b0, 1'b1, 8'h09);

    // in_valid low changes nothing but draining
    @(posedge clk);
    #1;
    expect_idle("idle_drain");

    // Reset mid-packet: SOP pending and channel state are lost
    send(8'h7A); send(8'h7C);
    reset_n = 1'b0;
    #1;
    chk("async_reset_out", {13'd0, obs_vec()}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h55); expect_out("post_reset_55", 8'h55, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mm_console_master_b2p.md
# mm_console_master_b2p

Byte-stream-to-packet decoder in the console master path. It sits directly downstream of the console timing adapter, which emits raw 8-bit bytes with ready backpressure. It strips the in-band framing bytes (SOP, EOP, channel, escape) and emits a packetised Avalon-ST byte stream with start/end-of-packet flags and a channel field toward the packet-to-master stage. There is one output register stage with full-throughput ready/valid on both sides.

## Interface
Parameters:
- CHANNEL_WIDTH, 8: width of out_channel, 1..8; the channel byte is truncated to its LSBs.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  decoded data byte valid.
- out_data  out  8  decoded data byte.
- out_startofpacket  out  1  first byte of packet.
- out_endofpacket  out  1  last byte of packet.
- out_channel  out  CHANNEL_WIDTH  channel of this byte.
- out_ready  in  1  downstream ready; transfer on out_valid && out_ready.

## Operation
- Special bytes: SOP=0x7A, EOP=0x7B, CHAN=0x7C, ESC=0x7D.
- Decoder FSM (advances only on accepted input bytes):
  - S_DATA:
    - 0x7A sets sop_pend; 0x7B sets eop_pend; 0x7C goes to S_CHAN; 0x7D goes to S_ESC. None of these produce output.
    - Any other byte is emitted as data.
  - S_ESC: the byte XOR 0x20 is emitted as data, unconditionally (even 0x7A..0x7D after XOR); next state S_DATA.
  - S_CHAN:
    - 0x7D goes to S_CHAN_ESC.
    - 0x7A/0x7B/0x7C are handled as markers exactly as in S_DATA (0x7C stays in S_CHAN); the channel is unchanged.
    - Any other byte is loaded into chan_reg; next state S_DATA.
  - S_CHAN_ESC: chan_reg <= byte ^ 0x20; next state S_DATA.
- Data emission:
  - Loads the output register with data, out_startofpacket=sop_pend, out_endofpacket=eop_pend, out_channel=chan_reg (the new value if it was updated on an earlier byte).
  - Clears sop_pend and eop_pend in the same cycle.
- Sticky state:
  - chan_reg persists across packets.
  - Repeated 0x7A or 0x7B before data is idempotent.
  - SOP and EOP may both flag the same byte (single-byte packet).
- No packet-structure checking: a missing SOP/EOP is passed through as-is.

## Timing
- in_ready = !out_valid || out_ready (combinational). Marker bytes are also gated by in_ready.
- Latency: a data byte accepted at edge N is presented on out_* after edge N; 1 cycle.
- Escaped data: the ESC byte takes one accepted cycle; the data appears 1 cycle after the following byte.
- Throughput: 1 data byte/cycle with out_ready held high; markers cost one input cycle each.
- Backpressure: out_* hold stable while out_valid && !out_ready. A simultaneous out transfer and new data load is allowed.
- Reset (async assert, sync release): out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, chan_reg=0, sop_pend=0, eop_pend=0, FSM=S_DATA. A byte in flight is discarded and pending flags are lost.
- in_valid low: no state change.

## Structure
- Shared package `mm_console_pkg`: the byte constants SOP/EOP/CHAN/ESC, ESC_XOR=0x20, and the FSM state enum, all reused by a future packets-to-bytes encoder.
- No sub-module: a single FSM plus one output register slice. If the output slice is reused elsewhere, it may be split out as `mm_console_st_reg`.

## Test plan
- Plain stream: bytes 0x7A,0x11,0x22,0x7B,0x33 with out_ready=1 → out 0x11(SOP),0x22,0x33(EOP), channel 0, one byte/cycle after markers.
- Escapes: 0x7D,0x5A then 0x7D,0x5D → data 0x7A then 0x7D, no flags set.
- Channel: 0x7C,0x05,0x7A,0x7B,0xAA then 0x7C,0x7D,0x5C,0xBB → 0xAA with SOP+EOP on ch 5, then 0xBB on ch 0x7C (CHANNEL_WIDTH=8).
- Backpressure: hold out_ready=0 for 3 cycles mid-packet → in_ready=0, out_* stable, no byte lost or duplicated; the stream resumes in order.
- Marker in S_CHAN: 0x7C,0x7A,0x09,0x44 → SOP pending, chan=9, 0x44 emitted with SOP on ch 9.
- Reset mid-packet: assert reset_n=0 after 0x7A,0x7C → outputs 0 immediately; then 0x55 → 0x55 without SOP on ch 0.
